// File: rtl/data_ram_seq.sv
// Sequential data RAM: direct / indirect / indexed / index-load access, swept clear after reset.
// Optional DATA_RAM_INDIRECT_EN builds the PTR state for mode 01; otherwise mode 01 acts as direct.
module data_ram_seq #(
    parameter int width  = 8,
    parameter int length = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              writeEnable,
    input  logic [1:0]        mode,
    input  logic [length-1:0] addr,
    input  logic [width-1:0]  writeData,
    output logic [width-1:0]  readData,
    output logic              dataReady,
    output logic              busy,
    output logic [1:0]        o_dbg_state
);
    localparam int DEPTH = 2 ** length;

    // Handshake: req is taken only at an edge where busy is low; while busy is high req is
    // dropped, never queued. dataReady is a one-cycle pulse marking readData as freshly valid.
    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1
`ifdef DATA_RAM_INDIRECT_EN
        , S_PTR = 2'd2
`endif
    } state_t;

    state_t            r_state, w_next_state;
    logic [length-1:0] r_cnt, w_next_cnt;
    logic [length-1:0] r_idx, w_next_idx;
    logic [width-1:0]  r_rdata;
    logic              r_rdy;
    logic [width-1:0]  r_mem [DEPTH];

    logic              w_we;
    logic [length-1:0] w_waddr;
    logic [width-1:0]  w_wdata;
    logic              w_re;
    logic [length-1:0] w_raddr;
    logic [length-1:0] w_acc_addr;
    logic [1:0]        w_mode;

`ifdef DATA_RAM_INDIRECT_EN
    logic [length-1:0] r_ptr, w_next_ptr;
    logic              r_pwe, w_next_pwe;
    assign w_mode = mode;
`else
    assign w_mode = (mode == 2'b01) ? 2'b00 : mode;
`endif

    assign w_acc_addr = (w_mode == 2'b10) ? (addr + r_idx) : addr;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_idx   = r_idx;
        w_we         = 1'b0;
        w_waddr      = r_cnt;
        w_wdata      = '0;
        w_re         = 1'b0;
        w_raddr      = w_acc_addr;
`ifdef DATA_RAM_INDIRECT_EN
        w_next_ptr   = r_ptr;
        w_next_pwe   = r_pwe;
`endif
        case (r_state)
            S_CLEAR: begin
                w_we       = 1'b1;
                w_next_cnt = r_cnt + 1'b1;
                if (&r_cnt) w_next_state = S_IDLE;
            end
            S_IDLE: begin
                if (req) begin
                    case (w_mode)
                        2'b00, 2'b10: begin
                            if (w_mode == 2'b10) w_next_idx = r_idx + 1'b1;
                            if (writeEnable) begin
                                w_we    = 1'b1;
                                w_waddr = w_acc_addr;
                                w_wdata = writeData;
                            end else begin
                                w_re = 1'b1;
                            end
                        end
`ifdef DATA_RAM_INDIRECT_EN
                        2'b01: begin
                            // Pointer is frozen here; addr may change freely during PTR.
                            w_next_ptr   = length'(r_mem[addr]);
                            w_next_pwe   = writeEnable;
                            w_next_state = S_PTR;
                        end
`endif
                        2'b11: w_next_idx = length'(writeData);
                        default: ;
                    endcase
                end
            end
`ifdef DATA_RAM_INDIRECT_EN
            S_PTR: begin
                w_next_state = S_IDLE;
                if (r_pwe) begin
                    w_we    = 1'b1;
                    w_waddr = r_ptr;
                    w_wdata = writeData;
                end else begin
                    w_re    = 1'b1;
                    w_raddr = r_ptr;
                end
            end
`endif
            default: w_next_state = S_CLEAR;
        endcase
    end

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_rdy   <= 1'b0;
`ifdef DATA_RAM_INDIRECT_EN
            r_ptr   <= '0;
            r_pwe   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_idx   <= w_next_idx;
            r_rdy   <= w_re;
            if (w_re) r_rdata <= r_mem[w_raddr];
`ifdef DATA_RAM_INDIRECT_EN
            r_ptr   <= w_next_ptr;
            r_pwe   <= w_next_pwe;
`endif
        end
    end

    // Array has no reset; gating on clr keeps it untouched while reset is held.
    always_ff @(negedge clk) begin
        if (clr && w_we) r_mem[w_waddr] <= w_wdata;
    end

    assign readData    = r_rdata;
    assign dataReady   = r_rdy;
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule
